noise_gate: RTL and testbench

- Per-sample audio noise gate at the input of the application core, ahead of the delay/chorus/tremolo chain.
- Tracks a peak envelope of the incoming signed sample stream and opens or closes a gain ramp using open/close thresholds with hysteresis and a hold time.
- Muted samples leave as zero; open samples pass at unity gain.
- Fills the NOISEGATE_EN slot in the main configuration. THRESHOLD takes its default from NOISEGATE_THRESHOLD.

---
 rtl/noise_gate.sv | 194 +++++++++++++++++++
 tb/tb_noise_gate.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/noise_gate.sv
// Per-sample audio noise gate: peak envelope follower driving a hysteretic
// open/close gain ramp with a hold time. Two-cycle sample latency.
module noise_gate #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned THRESHOLD    = 300,
    parameter int unsigned HYSTERESIS   = 64,
    parameter int unsigned HOLD_SAMPLES = 2400,
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_n_i,
    input  logic                  en_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic                  sample_valid_o,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  gate_open_o,
    output logic [DATA_WIDTH-2:0] env_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned EW = DATA_WIDTH - 1;
    localparam int unsigned GW = 9;
    localparam int unsigned PW = DATA_WIDTH + 10;
    localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [EW-1:0] OPEN_TH  = EW'(THRESHOLD);
    localparam logic [EW-1:0] CLOSE_TH = EW'(THRESHOLD - HYSTERESIS);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES - 1);
    localparam logic [GW-1:0] GAIN_UNITY = 9'd256;
    // Steps at or above unity are clamped so a single update reaches the limit
    localparam logic [GW:0]   ATK_STEP = (ATTACK_STEP >= 256) ? 10'd256 : 10'(ATTACK_STEP);
    localparam logic [GW-1:0] REL_STEP = (RELEASE_STEP >= 256) ? 9'd256 : 9'(RELEASE_STEP);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         gain_q, gain_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [EW-1:0]         env_q;
    logic                  gate_open_c;

    logic [EW-1:0]         abs_c;
    logic [EW-1:0]         env_dec_c;
    logic [EW-1:0]         env_nxt_c;
    logic [GW:0]           gain_sum_c;
    logic [GW-1:0]         gain_up_c;
    logic [GW-1:0]         gain_dn_c;

    logic signed [DW-1:0]  sample_d;
    logic                  valid_d;
    logic signed [PW-1:0]  samp_ext_c;
    logic signed [PW-1:0]  gain_ext_c;
    logic signed [PW-1:0]  prod_c;
    logic                  prod_unused_c;

    assign env_o = env_q;

    // Saturated magnitude and peak envelope with exponential decay
    always_comb begin
        abs_c = '0;
        if (sample_i[DW-1]) begin
            if (sample_i[EW-1:0] == '0) begin
                abs_c = '1;
            end else begin
                abs_c = EW'(-sample_i);
            end
        end else begin
            abs_c = sample_i[EW-1:0];
        end
        env_dec_c = env_q - (env_q >> DECAY_SHIFT);
        env_nxt_c = (abs_c > env_dec_c) ? abs_c : env_dec_c;
    end

    // Saturating gain ramp candidates
    always_comb begin
        gain_sum_c = {1'b0, gain_q} + ATK_STEP;
        gain_up_c  = (gain_sum_c >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum_c[GW-1:0];
        gain_dn_c  = (gain_q <= REL_STEP) ? '0 : gain_q - REL_STEP;
    end

    // Next-state, gain and hold counter; env is the pre-edge value (one-sample lag)
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (!en_i) begin
            state_d = ST_OPEN;
            gain_d  = GAIN_UNITY;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if (env_q >= OPEN_TH) begin
                        state_d = ST_ATTACK;
                        gain_d  = gain_up_c;
                    end
                end
                ST_ATTACK: begin
                    gain_d = gain_up_c;
                    if (gain_up_c == GAIN_UNITY) begin
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (env_q < CLOSE_TH) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    if (env_q >= OPEN_TH) begin
                        state_d = ST_OPEN;
                    end else if (hold_q == '0) begin
                        state_d = ST_RELEASE;
                        gain_d  = gain_dn_c;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (env_q >= OPEN_TH) begin
                        state_d = ST_ATTACK;
                        gain_d  = gain_up_c;
                    end else begin
                        gain_d = gain_dn_c;
                        if (gain_dn_c == '0) begin
                            state_d = ST_CLOSED;
                        end
                    end
                end
                default: begin
                    state_d = ST_CLOSED;
                    gain_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
        gate_open_c = (state_d == ST_ATTACK) || (state_d == ST_OPEN) || (state_d == ST_HOLD);
    end

    // Control state register, advanced once per input sample
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q     <= ST_CLOSED;
            gain_q      <= '0;
            hold_q      <= '0;
            env_q       <= '0;
            gate_open_o <= 1'b0;
        end else if (sample_valid_i) begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_q      <= hold_d;
            env_q       <= env_nxt_c;
            gate_open_o <= gate_open_c;
        end
    end

    // Gain multiply: Q8 gain, arithmetic shift keeps only the integer part
    always_comb begin
        samp_ext_c    = PW'(sample_d);
        gain_ext_c    = PW'({1'b0, gain_q});
        prod_c        = samp_ext_c * gain_ext_c;
        prod_unused_c = ^{prod_c[PW-1:DW+8], prod_c[7:0]};
    end

    // Two-stage sample pipeline: capture on the strobe, scale on the next edge
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            sample_d       <= '0;
            valid_d        <= 1'b0;
            sample_valid_o <= 1'b0;
            sample_o       <= '0;
        end else begin
            valid_d        <= sample_valid_i;
            sample_valid_o <= valid_d;
            if (sample_valid_i) begin
                sample_d <= sample_i;
            end
            if (valid_d) begin
                sample_o <= prod_c[DW+7:8];
            end
        end
    end

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate with short hold and coarse ramp steps.
module tb_noise_gate;

    logic               clk;
    logic               srst_n;
    logic               en;
    logic               valid_in;
    logic signed [23:0] samp_in;
    logic               valid_out;
    logic signed [23:0] samp_out;
    logic               gate_open;
    logic [22:0]        env;

    int errors = 0;
    int checks = 0;

    logic signed [23:0] obs_out;
    logic               obs_gate;
    logic [22:0]        obs_env;

    noise_gate #(
        .DATA_WIDTH  (24),
        .THRESHOLD   (300),
        .HYSTERESIS  (64),
        .HOLD_SAMPLES(4),
        .DECAY_SHIFT (1),
        .ATTACK_STEP (64),
        .RELEASE_STEP(64)
    ) dut (
        .clk_i         (clk),
        .srst_n_i      (srst_n),
        .en_i          (en),
        .sample_valid_i(valid_in),
        .sample_i      (samp_in),
        .sample_valid_o(valid_out),
        .sample_o      (samp_out),
        .gate_open_o   (gate_open),
        .env_o         (env)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One strobe; verifies the 2-cycle output strobe and that sample_o holds
    task automatic send(input logic signed [23:0] s);
        @(negedge clk);
        samp_in  = s;
        valid_in = 1'b1;
        @(posedge clk); #1;
        check("vld_edge_n", longint'(valid_out), 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("vld_edge_n1", longint'(valid_out), 1);
        obs_out  = samp_out;
        obs_gate = gate_open;
        obs_env  = env;
        @(posedge clk); #1;
        check("vld_edge_n2", longint'(valid_out), 0);
        check("out_hold", longint'(samp_out), longint'(obs_out));
    endtask

    int exp_ramp_out[6]  = '{0, 250, 500, 750, 1000, 1000};
    int exp_ramp_gate[6] = '{0, 1, 1, 1, 1, 1};
    int exp_rel_out[11]  = '{100, 100, 100, 100, 100, 100, 100, 75, 50, 25, 0};
    int exp_rel_gate[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int exp_rel_env[11]  = '{500, 250, 125, 100, 100, 100, 100, 100, 100, 100, 100};
    int re_in[6]         = '{1000, -1, 1000, 1000, 1000, 1000};
    int re_out[6]        = '{0, -1, 500, 750, 1000, 1000};
    int inj_out[3]       = '{500, 750, 1000};
    int inj_gate[3]      = '{0, 1, 1};

    initial begin
        logic signed [23:0] r;
        int  n;
        bit  seen;

        srst_n   = 1'b0;
        en       = 1'b1;
        valid_in = 1'b0;
        samp_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(valid_out), 0);
        check("rst_out", longint'(samp_out), 0);
        check("rst_gate", longint'(gate_open), 0);
        check("rst_env", longint'(env), 0);
        @(negedge clk);
        srst_n = 1'b1;

        // Silence keeps the gate shut
        for (int i = 0; i < 8; i++) begin
            send(24'sd0);
            check("zero_out", longint'(obs_out), 0);
            check("zero_gate", longint'(obs_gate), 0);
            check("zero_env", longint'(obs_env), 0);
        end

        // Attack ramp from CLOSED
        for (int i = 0; i < 6; i++) begin
            send(24'sd1000);
            check("atk_out", longint'(obs_out), longint'(exp_ramp_out[i]));
            check("atk_gate", longint'(obs_gate), longint'(exp_ramp_gate[i]));
        end

        // Envelope decay, hold, release to CLOSED
        for (int i = 0; i < 11; i++) begin
            send(24'sd100);
            check("rel_out", longint'(obs_out), longint'(exp_rel_out[i]));
            check("rel_gate", longint'(obs_gate), longint'(exp_rel_gate[i]));
            check("rel_env", longint'(obs_env), longint'(exp_rel_env[i]));
        end

        // Reopen; -1 at gain 64 floors to -1
        for (int i = 0; i < 6; i++) begin
            send(24'(re_in[i]));
            check("reopen_out", longint'(obs_out), longint'(re_out[i]));
            check("reopen_gate", longint'(obs_gate), longint'(exp_ramp_gate[i]));
        end

        // Back into release, then a loud burst mid-ramp
        for (int i = 0; i < 8; i++) begin
            send(24'sd100);
            check("rel2_out", longint'(obs_out), longint'(exp_rel_out[i]));
            check("rel2_gate", longint'(obs_gate), longint'(exp_rel_gate[i]));
        end
        for (int i = 0; i < 3; i++) begin
            send(24'sd1000);
            check("inject_out", longint'(obs_out), longint'(inj_out[i]));
            check("inject_gate", longint'(obs_gate), longint'(inj_gate[i]));
        end

        // Most negative sample at unity gain
        send(-24'sd8388608);
        check("minneg_out", longint'(obs_out), -64'sd8388608);
        check("minneg_env", longint'(obs_env), 8388607);
        check("minneg_gate", longint'(obs_gate), 1);
        send(24'sd1000);
        check("after_min_out", longint'(obs_out), 1000);

        // Bypass: output mirrors input
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = 24'($urandom);
            send(r);
            check("byp_out", longint'(obs_out), longint'(r));
            check("byp_gate", longint'(obs_gate), 1);
        end

        // Re-enable from OPEN and let silence drive it into RELEASE
        en   = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            send(24'sd0);
            n++;
            if (!obs_gate) seen = 1'b1;
        end
        check("reach_release", longint'(seen), 1);

        // Reset mid-release
        @(negedge clk);
        srst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", longint'(valid_out), 0);
        check("mrst_out", longint'(samp_out), 0);
        check("mrst_gate", longint'(gate_open), 0);
        check("mrst_env", longint'(env), 0);
        @(negedge clk);
        srst_n = 1'b1;

        // Starts from CLOSED with zero envelope
        send(24'sd1000);
        check("post_rst_out0", longint'(obs_out), 0);
        check("post_rst_gate0", longint'(obs_gate), 0);
        check("post_rst_env0", longint'(obs_env), 1000);
        send(24'sd1000);
        check("post_rst_out1", longint'(obs_out), 250);
        check("post_rst_gate1", longint'(obs_gate), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
